led_matrix_scanner: RTL and testbench

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

---
 rtl/led_matrix_scanner.sv | 141 ++++++++++++++
 tb/tb_led_matrix_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 16x16 LED matrix scanner with double-buffered frame storage.
// Each row gets a blanking gap followed by a dwell period; new frames commit only at frame end.
module led_matrix_scanner #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [255:0] frame_in,
    input  logic         frame_load,
    output logic [15:0]  row_sel,
    output logic [15:0]  col_data,
    output logic [3:0]   row_idx,
    output logic         load_pending,
    output logic         frame_done
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [3:0]     row_q, row_d;
    logic [255:0]   staging_q, staging_d;
    logic [255:0]   display_q, display_d;
    logic           pending_q, pending_d;
    logic [15:0]    row_sel_q, row_sel_d;
    logic [15:0]    col_data_q, col_data_d;
    logic           frame_done_q, frame_done_d;
    logic           commit_s;

    // Next-state logic for the scan sequencer, frame buffers and output registers
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        staging_d    = staging_q;
        display_d    = display_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        commit_s     = en && (state_q == ST_DRIVE) && (cnt_q == DWELL_LAST) && (row_q == 4'd15);

        if (!en) begin
            state_d = ST_BLANK;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d      = ST_BLANK;
                        cnt_d        = 16'd0;
                        row_d        = row_q + 4'd1;
                        frame_done_d = commit_s;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        // A load landing on the commit edge bypasses the pending stage entirely
        if (clr) begin
            staging_d = 256'd0;
            display_d = 256'd0;
            pending_d = 1'b0;
        end else if (frame_load) begin
            staging_d = frame_in;
            if (commit_s) begin
                display_d = frame_in;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (commit_s && pending_q) begin
            display_d = staging_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        // Outputs track the next state so they line up with the registered state
        if (state_d == ST_DRIVE) begin
            row_sel_d  = ~(16'd1 << row_d);
            col_data_d = display_d[{row_d, 4'd0} +: 16];
        end else begin
            row_sel_d  = 16'hFFFF;
            col_data_d = 16'd0;
        end
    end

    // State, buffer and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= 16'd0;
            row_q        <= 4'd0;
            staging_q    <= 256'd0;
            display_q    <= 256'd0;
            pending_q    <= 1'b0;
            row_sel_q    <= 16'hFFFF;
            col_data_q   <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            staging_q    <= staging_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_sel      = row_sel_q;
    assign col_data     = col_data_q;
    assign row_idx      = row_q;
    assign load_pending = pending_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: directed table, corner sequences and
// randomized traffic compared cycle by cycle against a row/phase reference model.
module tb_led_matrix_scanner;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int RP = DW + BL;

    logic         clk = 1'b0;
    logic         rst_n, clr, en, frame_load;
    logic [255:0] frame_in;
    logic [15:0]  row_sel, col_data;
    logic [3:0]   row_idx;
    logic         load_pending, frame_done;

    always #5 clk = ~clk;

    led_matrix_scanner #(.DWELL(DW), .BLANK(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .en           (en),
        .frame_in     (frame_in),
        .frame_load   (frame_load),
        .row_sel      (row_sel),
        .col_data     (col_data),
        .row_idx      (row_idx),
        .load_pending (load_pending),
        .frame_done   (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase within the row period and row number
    logic [15:0] m_stage [16];
    logic [15:0] m_disp  [16];
    logic        m_pend, m_fd;
    int          m_p, m_r;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] cd;
        logic [3:0]  ri;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit commit;
        commit = en && (m_p == RP - 1) && (m_r == 15);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_stage[i] = 16'd0;
                m_disp[i]  = 16'd0;
            end
            m_pend = 1'b0; m_fd = 1'b0; m_p = 0; m_r = 0;
        end else begin
            if (clr) begin
                for (int i = 0; i < 16; i++) begin
                    m_stage[i] = 16'd0;
                    m_disp[i]  = 16'd0;
                end
                m_pend = 1'b0;
            end else if (frame_load) begin
                for (int i = 0; i < 16; i++) m_stage[i] = frame_in[16*i +: 16];
                if (commit) begin
                    for (int i = 0; i < 16; i++) m_disp[i] = m_stage[i];
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end else if (commit && m_pend) begin
                for (int i = 0; i < 16; i++) m_disp[i] = m_stage[i];
                m_pend = 1'b0;
            end
            m_fd = commit;
            if (!en) m_p = 0;
            else if (m_p == RP - 1) begin m_p = 0; m_r = (m_r + 1) % 16; end
            else m_p++;
        end
    endtask

    task automatic check_model();
        logic [15:0] ers, ecd;
        if (m_p < BL) begin
            ers = 16'hFFFF; ecd = 16'd0;
        end else begin
            ers = ~(16'd1 << m_r); ecd = m_disp[m_r];
        end
        check("model_row_sel", row_sel, ers);
        check("model_col_data", col_data, ecd);
        check("model_row_idx", row_idx, m_r[3:0]);
        check("model_load_pending", load_pending, m_pend);
        check("model_frame_done", frame_done, m_fd);
    endtask

    task automatic step(input logic e, input logic c, input logic l, input logic [255:0] f);
        en = e; clr = c; frame_load = l; frame_in = f;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 256'd0);
    endtask

    task automatic run_until_fd();
        for (int n = 0; n < 200; n++) begin
            step(1'b1, 1'b0, 1'b0, 256'd0);
            if (frame_done) break;
        end
        check("frame_done_timeout", frame_done, 1'b1);
    endtask

    function automatic logic [255:0] rand_frame();
        logic [255:0] f;
        for (int i = 0; i < 16; i++) f[16*i +: 16] = 16'($urandom) | 16'h0001;
        return f;
    endfunction

    logic [255:0] f1, f2, f3, f4;

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0000, 4'd0};
        tbl[1] = '{16'hFFFF, 16'h0000, 4'd0};
        tbl[2] = '{16'hFFFE, 16'h0000, 4'd0};
        tbl[3] = '{16'hFFFE, 16'h0000, 4'd0};
        tbl[4] = '{16'hFFFE, 16'h0000, 4'd0};
        tbl[5] = '{16'hFFFE, 16'h0000, 4'd0};
        tbl[6] = '{16'hFFFF, 16'h0000, 4'd1};

        rst_n = 1'b0; en = 1'b1; clr = 1'b0; frame_load = 1'b0; frame_in = 256'd0;
        step(1'b1, 1'b0, 1'b0, 256'd0);
        step(1'b1, 1'b0, 1'b0, 256'd0);
        check("reset_frame_done", frame_done, 1'b0);

        // Post-reset scan timing
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) steps(1);
            check("tbl_row_sel", row_sel, tbl[i].rs);
            check("tbl_col_data", col_data, tbl[i].cd);
            check("tbl_row_idx", row_idx, tbl[i].ri);
        end

        // Mid-frame load commits only at frame end
        f1 = 256'd0; f1[15:0] = 16'h0055; f1[47:32] = 16'h0024;
        steps(20);
        step(1'b1, 1'b0, 1'b1, f1);
        check("load_pending_set", load_pending, 1'b1);
        run_until_fd();
        check("load_pending_clr", load_pending, 1'b0);
        steps(2);
        check("f1_row0_sel", row_sel, 16'hFFFE);
        check("f1_row0_col", col_data, 16'h0055);
        steps(12);
        check("f1_row2_sel", row_sel, 16'hFFFB);
        check("f1_row2_col", col_data, 16'h0024);

        // Two loads in one frame: last wins
        f2 = 256'd0; f2[15:0] = 16'h0055;
        step(1'b1, 1'b0, 1'b1, f2);
        steps(5);
        f2[15:0] = 16'h0064;
        step(1'b1, 1'b0, 1'b1, f2);
        run_until_fd();
        steps(2);
        check("last_load_col", col_data, 16'h0064);

        // Load on the commit edge
        run_until_fd();
        steps(RP * 16 - 1);
        f3 = rand_frame();
        step(1'b1, 1'b0, 1'b1, f3);
        check("commit_edge_fd", frame_done, 1'b1);
        check("commit_edge_pending", load_pending, 1'b0);
        steps(2);
        check("commit_edge_col", col_data, f3[15:0]);

        // Clear during row 7 drive
        steps(7 * RP);
        check("pre_clr_col", col_data, f3[127:112]);
        step(1'b1, 1'b1, 1'b0, 256'd0);
        check("clr_col", col_data, 16'h0000);
        check("clr_row_sel", row_sel, 16'hFF7F);
        check("clr_row_idx", row_idx, 4'd7);
        steps(2);
        check("clr_row_hold", row_idx, 4'd7);
        steps(1);
        check("clr_row_next", row_idx, 4'd8);

        // Enable pause during row 3
        f4 = rand_frame();
        step(1'b1, 1'b0, 1'b1, f4);
        run_until_fd();
        steps(3 * RP + 3);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 256'd0);
            check("pause_row_sel", row_sel, 16'hFFFF);
            check("pause_row_idx", row_idx, 4'd3);
        end
        steps(1);
        check("resume_blank", row_sel, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            steps(1);
            check("resume_drive_sel", row_sel, 16'hFFF7);
            check("resume_drive_col", col_data, f4[63:48]);
        end
        steps(1);
        check("resume_next_row", row_idx, 4'd4);

        // Pause on the last drive cycle of row 15 suppresses frame_done
        run_until_fd();
        steps(RP * 16 - 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 256'd0);
            check("pause_no_fd", frame_done, 1'b0);
        end
        run_until_fd();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 19) == 0), rand_frame());
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
